// File: rtl/two_bit_and_stream_pkg.sv
// rtl/two_bit_and_stream_pkg.sv - types and helpers for the buffered AND stream stage
package two_bit_and_stream_pkg;
`include "two_bit_and_defs.v"
   localparam int OP_W = `TBA_OP_W;
   localparam logic [OP_W-1:0] HIT_PAT = `TBA_HIT_PAT;

   typedef struct packed {
      logic [OP_W-1:0] a;
      logic [OP_W-1:0] b;
   } pair_t;

   function automatic logic is_hit(input logic [OP_W-1:0] v);
      return v == HIT_PAT;
   endfunction
endpackage

// File: rtl/two_bit_and.sv
// rtl/two_bit_and.sv - bitwise AND of two operands
module two_bit_and
   import two_bit_and_stream_pkg::*;
(
   input  logic [OP_W-1:0] i_a,
   input  logic [OP_W-1:0] i_b,
   output logic [OP_W-1:0] o_y
);
   assign o_y = i_a & i_b;
endmodule

// File: rtl/two_bit_and_defs.v
// rtl/two_bit_and_defs.v - shared operand width and hit pattern constants
`ifndef TWO_BIT_AND_DEFS_V
`define TWO_BIT_AND_DEFS_V
`define TBA_OP_W    2
`define TBA_HIT_PAT 2'b11
`endif

// File: rtl/two_bit_and_stream.sv
// rtl/two_bit_and_stream.sv - FIFO-buffered AND stage with registered output and hit counter
module two_bit_and_stream
   import two_bit_and_stream_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OP_W-1:0]  o,
   input  logic             clr_count,
   output logic [CNT_W-1:0] hit_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   pair_t            r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             r_out_valid;
   logic [OP_W-1:0]  r_o;
   logic [CNT_W-1:0] r_hit_count;

   logic             w_push;
   logic             w_load;
   logic             w_deliver;
   pair_t            w_head;
   logic [OP_W-1:0]  w_and;

   // Ready depends only on occupancy, so a full FIFO never accepts even while popping.
   assign in_ready  = (r_count < FULL_CNT);
   assign w_push    = in_valid && in_ready;
   assign w_load    = (r_count != '0) && (!r_out_valid || out_ready);
   assign w_deliver = r_out_valid && out_ready;
   assign w_head    = r_mem[r_rd_ptr];

   two_bit_and u_and (
      .i_a (w_head.a),
      .i_b (w_head.b),
      .o_y (w_and)
   );

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= '{a: a, b: b};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
         r_o         <= '0;
         r_hit_count <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_load) r_rd_ptr <= r_rd_ptr + PTR_W'(1);

         if (w_push && !w_load)      r_count <= r_count + (PTR_W+1)'(1);
         else if (!w_push && w_load) r_count <= r_count - (PTR_W+1)'(1);

         if (w_load) begin
            r_o         <= w_and;
            r_out_valid <= 1'b1;
         end else if (w_deliver) begin
            r_out_valid <= 1'b0;
         end

         if (clr_count)
            r_hit_count <= '0;
         else if (w_deliver && is_hit(r_o) && (r_hit_count != '1))
            r_hit_count <= r_hit_count + CNT_W'(1);
      end
   end

   assign out_valid = r_out_valid;
   assign o         = r_o;
   assign hit_count = r_hit_count;
endmodule

// File: tb/tb_two_bit_and_stream.sv
// tb/tb_two_bit_and_stream.sv - scoreboard bench for two_bit_and_stream
module tb_two_bit_and_stream;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [1:0]       a = 2'b00;
   logic [1:0]       b = 2'b00;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [1:0]       o;
   logic             clr_count = 1'b0;
   logic [CNT_W-1:0] hit_count;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [1:0] exp_q[$];
   int         hit_model = 0;

   two_bit_and_stream #(.DEPTH(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .o(o),
      .clr_count(clr_count), .hit_count(hit_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // Monitor: pops the scoreboard on every output handshake and tracks the hit count.
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         hit_model = 0;
      end else begin
         check("hit_count", int'(hit_count), hit_model);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", int'(o), -1);
            end else begin
               logic [1:0] e;
               e = exp_q.pop_front();
               check("result", int'(o), int'(e));
            end
         end
         if (clr_count)
            hit_model = 0;
         else if (out_valid && out_ready && o == 2'b11 && hit_model != 3)
            hit_model++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] va, input logic [1:0] vb, input logic [1:0] ve);
      bit done = 0;
      in_valid = 1'b1;
      a = va;
      b = vb;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(ve);
            done = 1;
         end
         step();
      end
      if (!done) check("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit done = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         step();
         if (exp_q.size() == 0 && !out_valid) done = 1;
      end
      check("drain_done", int'(done), 1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_o", int'(o), 0);
      check("rst_hit", int'(hit_count), 0);
      reset = 1'b0;
      step();

      // Mid-stream reset with entries queued
      out_ready = 1'b0;
      send(2'b11, 2'b11, 2'b11);
      send(2'b10, 2'b10, 2'b10);
      send(2'b01, 2'b11, 2'b01);
      send(2'b11, 2'b10, 2'b10);
      #3;
      reset = 1'b1;
      #1;
      check("mid_rst_out_valid", int'(out_valid), 0);
      check("mid_rst_o", int'(o), 0);
      check("mid_rst_hit", int'(hit_count), 0);
      check("mid_rst_in_ready", int'(in_ready), 1);
      exp_q.delete();
      step();
      reset = 1'b0;
      out_ready = 1'b1;
      send(2'b11, 2'b01, 2'b01);
      @(negedge clk);
      check("lat_edge1_valid", int'(out_valid), 0);
      step();
      @(negedge clk);
      check("lat_edge2_valid", int'(out_valid), 1);
      check("lat_edge2_o", int'(o), 1);
      drain();

      // Back-to-back streaming
      send(2'b11, 2'b11, 2'b11);
      send(2'b10, 2'b11, 2'b10);
      send(2'b01, 2'b01, 2'b01);
      send(2'b11, 2'b10, 2'b10);
      drain();
      check("stream_hit", int'(hit_count), 1);
      clr_count = 1'b1;
      step();
      clr_count = 1'b0;
      check("clr_hit", int'(hit_count), 0);

      // Full under backpressure
      out_ready = 1'b0;
      send(2'b11, 2'b11, 2'b11);
      send(2'b11, 2'b01, 2'b01);
      send(2'b10, 2'b11, 2'b10);
      send(2'b01, 2'b01, 2'b01);
      send(2'b11, 2'b10, 2'b10);
      in_valid = 1'b1;
      a = 2'b11;
      b = 2'b11;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("full_in_ready", int'(in_ready), 0);
         step();
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("full_same_cycle_ready", int'(in_ready), 0);
      step();
      @(negedge clk);
      check("full_ready_back", int'(in_ready), 1);
      exp_q.push_back(2'b11);
      step();
      in_valid = 1'b0;
      drain();

      // Simultaneous push and pop with two entries queued
      out_ready = 1'b0;
      send(2'b10, 2'b10, 2'b10);
      send(2'b01, 2'b11, 2'b01);
      send(2'b11, 2'b11, 2'b11);
      step();
      in_valid = 1'b1;
      a = 2'b11;
      b = 2'b01;
      out_ready = 1'b1;
      @(negedge clk);
      if (in_ready) exp_q.push_back(2'b01);
      check("simul_accept", int'(in_ready), 1);
      step();
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      check("simul_occupancy", int'(dut.r_count), 2);
      drain();

      // Saturation and clear-wins
      clr_count = 1'b1;
      step();
      clr_count = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) send(2'b11, 2'b11, 2'b11);
      drain();
      check("sat_hit", int'(hit_count), 3);
      out_ready = 1'b0;
      send(2'b11, 2'b11, 2'b11);
      step();
      check("clr_pre_valid", int'(out_valid), 1);
      out_ready = 1'b1;
      clr_count = 1'b1;
      step();
      clr_count = 1'b0;
      check("clr_wins", int'(hit_count), 0);
      drain();

      // Stall stability with toggling operands and in_valid low
      out_ready = 1'b0;
      send(2'b10, 2'b11, 2'b10);
      step();
      for (int i = 0; i < 10; i++) begin
         a = 2'(i);
         b = 2'(i + 1);
         step();
         check("stall_valid", int'(out_valid), 1);
         check("stall_o", int'(o), 2);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
